// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, decoder state encodings and key-event layout.
// Key events are {ext, brk, code[7:0]}.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_NUL    = 8'h00;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR    = 8'hFF;

   localparam int unsigned KEY_EXT = 9;
   localparam int unsigned KEY_BRK = 8;
   localparam int unsigned KEY_W   = 10;

   typedef logic [KEY_W-1:0] key_t;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StExt    = 3'd1;
   localparam logic [2:0] StBrk    = 3'd2;
   localparam logic [2:0] StExtBrk = 3'd3;
   localparam logic [2:0] StPause  = 3'd4;

   function automatic key_t make_key(input logic ext, input logic brk, input logic [7:0] code);
      return {ext, brk, code};
   endfunction

endpackage

// File: rtl/ps2_key_queue_if.sv
// Byte-input / CPU-drain bus of the PS/2 key queue.
// The slave modport is the queue itself.
interface ps2_key_queue_if
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0] byte_in;
   logic       byte_valid;
   logic [1:0] cfg;
   logic       pop;
   logic       clr_ovf;
   key_t       key_out;
   logic       empty;
   logic       full;
   logic [AW:0] count;
   logic       overflow;
   key_t       last_key;

   modport master (
      output byte_in, byte_valid, cfg, pop, clr_ovf,
      input  key_out, empty, full, count, overflow, last_key
   );

   modport slave (
      input  byte_in, byte_valid, cfg, pop, clr_ovf,
      output key_out, empty, full, count, overflow, last_key
   );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; a push on a full FIFO is accepted only alongside a pop.
// Output reads 0 while empty.
module sync_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];
   assign count   = count_q;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/ps2_key_queue.sv
// Decodes PS/2 scan-code bytes into {ext,brk,code} key events, filters
// releases/typematic repeats on request, and queues survivors for the CPU.
module ps2_key_queue
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned PAUSE_LEN = 7,
   localparam int unsigned AW       = $clog2(DEPTH),
   localparam int unsigned PW       = $clog2(PAUSE_LEN + 1)
) (
   input logic            clk,
   input logic            RSTN,
   ps2_key_queue_if.slave bus
);
   logic [2:0]    state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic          emit;
   key_t          ev;
   key_t          last_key_q, last_key_d;
   key_t          trk_q, trk_d;
   logic          trk_vld_q, trk_vld_d;
   logic          ovf_q, ovf_d;
   logic          is_brk, is_rep, push, fifo_full;
   logic [AW:0]   fifo_count;

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      emit    = 1'b0;
      ev      = '0;
      if (bus.byte_valid) begin
         case (state_q)
            StIdle: begin
               case (bus.byte_in)
                  PS2_EXT:   state_d = StExt;
                  PS2_BRK:   state_d = StBrk;
                  PS2_PAUSE: begin
                     state_d = StPause;
                     pcnt_d  = PW'(PAUSE_LEN);
                  end
                  PS2_NUL, PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ERR: state_d = StIdle;
                  default: begin
                     emit = 1'b1;
                     ev   = make_key(1'b0, 1'b0, bus.byte_in);
                  end
               endcase
            end
            StExt: begin
               if (bus.byte_in == PS2_BRK) begin
                  state_d = StExtBrk;
               end else begin
                  state_d = StIdle;
                  if (bus.byte_in != PS2_EXT && bus.byte_in != PS2_PAUSE) begin
                     emit = 1'b1;
                     ev   = make_key(1'b1, 1'b0, bus.byte_in);
                  end
               end
            end
            StBrk: begin
               state_d = StIdle;
               emit    = 1'b1;
               ev      = make_key(1'b0, 1'b1, bus.byte_in);
            end
            StExtBrk: begin
               state_d = StIdle;
               emit    = 1'b1;
               ev      = make_key(1'b1, 1'b1, bus.byte_in);
            end
            StPause: begin
               pcnt_d = pcnt_q - PW'(1);
               if (pcnt_q <= PW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Repeat tracker follows every decoded event, independent of cfg.
   always_comb begin
      is_brk     = ev[KEY_BRK];
      is_rep     = trk_vld_q && !is_brk && (ev == trk_q);
      push       = emit && !((bus.cfg[0] && is_brk) || (bus.cfg[1] && is_rep));
      last_key_d = emit ? ev : last_key_q;
      trk_d      = trk_q;
      trk_vld_d  = trk_vld_q;
      if (emit) begin
         if (!is_brk) begin
            trk_d     = ev;
            trk_vld_d = 1'b1;
         end else if (ev[KEY_EXT] == trk_q[KEY_EXT] && ev[7:0] == trk_q[7:0]) begin
            trk_vld_d = 1'b0;
         end
      end
      // A same-edge pop frees a slot, so that push is not an overflow; set beats clear.
      ovf_d = ovf_q;
      if (bus.clr_ovf) ovf_d = 1'b0;
      if (push && fifo_full && !bus.pop) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= StIdle;
         pcnt_q     <= '0;
         last_key_q <= '0;
         trk_q      <= '0;
         trk_vld_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         last_key_q <= last_key_d;
         trk_q      <= trk_d;
         trk_vld_q  <= trk_vld_d;
         ovf_q      <= ovf_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (KEY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (RSTN),
      .push  (push),
      .pop   (bus.pop),
      .din   (ev),
      .dout  (bus.key_out),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (bus.empty)
   );

   assign bus.full     = fifo_full;
   assign bus.count    = fifo_count;
   assign bus.overflow = ovf_q;
   assign bus.last_key = last_key_q;
endmodule

// File: tb/tb_ps2_key_queue.sv
// Self-checking bench for ps2_key_queue: table-driven byte vectors feeding a
// scoreboard queue, plus hand-written overflow and mid-sequence reset cases.
module tb_ps2_key_queue;
   import ps2_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic RSTN;
   always #5 clk = ~clk;

   ps2_key_queue_if #(.DEPTH(DEPTH)) bus ();

   ps2_key_queue #(
      .DEPTH     (DEPTH),
      .PAUSE_LEN (7)
   ) dut (
      .clk  (clk),
      .RSTN (RSTN),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0] cfg;
      logic [7:0] b;
      logic [9:0] last;
      logic       queued;
      logic       drain;
   } vec_t;

   vec_t       vecs [$];
   logic [9:0] sb [$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [1:0] cfg, input logic [7:0] b, input logic [9:0] last,
                      input logic queued, input logic drain);
      vecs.push_back('{cfg: cfg, b: b, last: last, queued: queued, drain: drain});
   endtask

   task automatic send(input logic [7:0] b, input logic p, input logic c);
      @(negedge clk);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.pop        = p;
      bus.clr_ovf    = c;
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.pop        = 1'b0;
      bus.clr_ovf    = 1'b0;
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         check("count", 32'(bus.count), sb.size());
         check("empty_n", 32'(bus.empty), 0);
         check("key_out", 32'(bus.key_out), 32'(sb[0]));
         bus.pop = 1'b1;
         @(negedge clk);
         bus.pop = 1'b0;
         void'(sb.pop_front());
      end
      check("drained_empty", 32'(bus.empty), 1);
      check("drained_key", 32'(bus.key_out), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_empty", 32'(bus.empty), 1);
      check("rst_full", 32'(bus.full), 0);
      check("rst_count", 32'(bus.count), 0);
      check("rst_ovf", 32'(bus.overflow), 0);
      check("rst_key", 32'(bus.key_out), 0);
      check("rst_last", 32'(bus.last_key), 0);
   endtask

   initial begin
      RSTN           = 1'b0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      bus.cfg        = 2'b00;
      bus.pop        = 1'b0;
      bus.clr_ovf    = 1'b0;

      // plain make/break
      add(2'b00, 8'h1C, 10'h01C, 1, 0);
      add(2'b00, 8'hF0, 10'h01C, 0, 0);
      add(2'b00, 8'h1C, 10'h11C, 1, 1);
      // break suppression with extended keys
      add(2'b01, 8'hE0, 10'h11C, 0, 0);
      add(2'b01, 8'h75, 10'h275, 1, 0);
      add(2'b01, 8'hE0, 10'h275, 0, 0);
      add(2'b01, 8'hF0, 10'h275, 0, 0);
      add(2'b01, 8'h75, 10'h375, 0, 1);
      // typematic repeat suppression
      add(2'b10, 8'h1D, 10'h01D, 1, 0);
      add(2'b10, 8'h1D, 10'h01D, 0, 0);
      add(2'b10, 8'h1D, 10'h01D, 0, 0);
      add(2'b10, 8'hF0, 10'h01D, 0, 0);
      add(2'b10, 8'h1D, 10'h11D, 1, 0);
      add(2'b10, 8'h1D, 10'h01D, 1, 1);
      // pause sequence swallowed, then BAT/ACK discarded
      add(2'b00, 8'hE1, 10'h01D, 0, 0);
      add(2'b00, 8'h14, 10'h01D, 0, 0);
      add(2'b00, 8'h77, 10'h01D, 0, 0);
      add(2'b00, 8'hE1, 10'h01D, 0, 0);
      add(2'b00, 8'hF0, 10'h01D, 0, 0);
      add(2'b00, 8'h14, 10'h01D, 0, 0);
      add(2'b00, 8'hF0, 10'h01D, 0, 0);
      add(2'b00, 8'h77, 10'h01D, 0, 0);
      add(2'b00, 8'h29, 10'h029, 1, 0);
      add(2'b00, 8'hAA, 10'h029, 0, 0);
      add(2'b00, 8'hFA, 10'h029, 0, 1);

      #12;
      check_reset_outputs();
      @(negedge clk);
      RSTN = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.cfg = vecs[i].cfg;
         send(vecs[i].b, 1'b0, 1'b0);
         check($sformatf("last_key[%0d]", i), 32'(bus.last_key), 32'(vecs[i].last));
         if (vecs[i].queued) sb.push_back(vecs[i].last);
         if (vecs[i].drain) drain();
      end

      // Fill past capacity: fifth make is dropped and flags overflow.
      bus.cfg = 2'b00;
      send(8'h15, 1'b0, 1'b0); sb.push_back(10'h015);
      send(8'h16, 1'b0, 1'b0); sb.push_back(10'h016);
      send(8'h21, 1'b0, 1'b0); sb.push_back(10'h021);
      send(8'h22, 1'b0, 1'b0); sb.push_back(10'h022);
      check("ovf_pre", 32'(bus.overflow), 0);
      send(8'h23, 1'b0, 1'b0);
      check("full_count", 32'(bus.count), DEPTH);
      check("full_flag", 32'(bus.full), 1);
      check("ovf_set", 32'(bus.overflow), 1);
      check("full_head", 32'(bus.key_out), 32'h015);
      check("full_last", 32'(bus.last_key), 32'h023);
      @(negedge clk);
      bus.clr_ovf = 1'b1;
      @(negedge clk);
      bus.clr_ovf = 1'b0;
      check("ovf_clr", 32'(bus.overflow), 0);
      // push + pop on a full queue
      send(8'h24, 1'b1, 1'b0);
      void'(sb.pop_front());
      sb.push_back(10'h024);
      check("pp_count", 32'(bus.count), DEPTH);
      check("pp_ovf", 32'(bus.overflow), 0);
      check("pp_head", 32'(bus.key_out), 32'h016);
      // clear and new overflow on the same edge: set wins
      send(8'h25, 1'b0, 1'b1);
      check("ovf_setwins", 32'(bus.overflow), 1);
      check("setwins_count", 32'(bus.count), DEPTH);
      drain();
      // pop while empty is ignored
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
      check("emptypop_count", 32'(bus.count), 0);
      check("emptypop_empty", 32'(bus.empty), 1);
      // push + pop on an empty queue: push only
      send(8'h26, 1'b1, 1'b0);
      sb.push_back(10'h026);
      check("ep_count", 32'(bus.count), 1);
      drain();

      // Reset mid-sequence abandons the pending break prefix.
      send(8'h27, 1'b0, 1'b0);
      sb.push_back(10'h027);
      send(8'hF0, 1'b0, 1'b0);
      @(negedge clk);
      RSTN = 1'b0;
      sb.delete();
      #1;
      check_reset_outputs();
      @(negedge clk);
      RSTN = 1'b1;
      send(8'h1C, 1'b0, 1'b0);
      check("post_rst_last", 32'(bus.last_key), 32'h01C);
      sb.push_back(10'h01C);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
